// File: rtl/ub_port_arbiter.sv
// rtl/ub_port_arbiter.sv - three-port unified buffer arbiter with round-robin and bounded locked ownership
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module ub_port_arbiter #(
    parameter int AW       = `ADDR_WIDTH,
    parameter int DW       = `BUFFER_WIDTH,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [2:0]      wr_en,
    input  logic [2:0]      lock,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            ub_req,
    output logic            ub_wr_en,
    output logic [AW-1:0]   ub_addr,
    output logic [DW-1:0]   ub_wdata,
    input  logic [DW-1:0]   ub_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    logic [0:0]    state;
    logic [1:0]    rr_ptr;
    logic [1:0]    owner;
    logic [CW-1:0] lock_cnt;

    logic          gnt_any;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand1;
    logic [1:0]    cand2;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign cand1 = inc3(rr_ptr);
    assign cand2 = inc3(cand1);

    // Reset masks the grant so nothing reaches the buffer while rst is high.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        if (!rst) begin
            if (state == S_IDLE) begin
                if (req[rr_ptr]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_ptr;
                end else if (req[cand1]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand1;
                end else if (req[cand2]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand2;
                end
            end else if (req[owner]) begin
                gnt_any = 1'b1;
                gnt_idx = owner;
            end
        end
    end

    always_comb begin
        gnt      = 3'b000;
        ub_wr_en = 1'b0;
        ub_addr  = '0;
        ub_wdata = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                ub_wr_en = wr_en[i];
                ub_addr  = addr[i*AW +: AW];
                ub_wdata = wdata[i*DW +: DW];
            end
        end
    end

    assign ub_req = gnt_any;
    assign rdata  = ub_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= 2'd0;
            owner    <= 2'd0;
            lock_cnt <= '0;
            rvalid   <= 3'b000;
        end else begin
            rvalid <= gnt & ~wr_en;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        rr_ptr <= inc3(gnt_idx);
                        // A one-cycle limit would expire immediately, so never enter OWNED then.
                        if (lock[gnt_idx] && (MAX_LOCK > 1)) begin
                            state    <= S_OWNED;
                            owner    <= gnt_idx;
                            lock_cnt <= CW'(1);
                        end
                    end
                end
                default: begin
                    // Any release hands lowest priority to the departing owner.
                    if (!gnt_any || !lock[owner] || (lock_cnt == CW'(MAX_LOCK - 1))) begin
                        state    <= S_IDLE;
                        rr_ptr   <= inc3(owner);
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// tb/tb_ub_port_arbiter.sv - directed and randomized checks of ub_port_arbiter against a behavioural model
module tb_ub_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ML = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req, wr_en, lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, ub_wdata, ub_rdata;
    logic            ub_req, ub_wr_en;
    logic [AW-1:0]   ub_addr;

    ub_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ub_req(ub_req), .ub_wr_en(ub_wr_en), .ub_addr(ub_addr),
        .ub_wdata(ub_wdata), .ub_rdata(ub_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: owner of -1 means round-robin mode.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_ptr   = 0;
    logic [2:0] m_rvalid = 3'b000;

    logic [2:0]    obs_gnt, obs_rvalid;
    logic          obs_ub_req, obs_ub_wr;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;

    bit track = 0;
    int wait_cnt [3] = '{0, 0, 0};
    int max_wait = 0;
    int reads_exp = 0;
    int rvalid_seen = 0;

    logic [2:0] rr_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [2:0] r, input logic rs);
        if (rs) return -1;
        if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
                if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
            end
            return -1;
        end
        return r[m_owner] ? m_owner : -1;
    endfunction

    task automatic do_cycle(input logic rs, input logic [2:0] r, input logic [2:0] w,
                            input logic [2:0] l, input logic [3*AW-1:0] a,
                            input logic [3*DW-1:0] d);
        int         g;
        logic [2:0] eg;
        rst = rs; req = r; wr_en = w; lock = l; addr = a; wdata = d;
        ub_rdata = DW'($urandom);
        g  = model_grant(r, rs);
        eg = (g >= 0) ? 3'(1 << g) : 3'b000;
        @(negedge clk);
        obs_gnt = gnt; obs_rvalid = rvalid; obs_ub_req = ub_req; obs_ub_wr = ub_wr_en;
        obs_addr = ub_addr; obs_wdata = ub_wdata;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("ub_req", 32'(ub_req), 32'(g >= 0));
        chk("rdata", 32'(rdata), 32'(ub_rdata));
        if (g >= 0) begin
            chk("ub_wr_en", 32'(ub_wr_en), 32'(w[g]));
            chk("ub_addr", 32'(ub_addr), 32'(a[g*AW +: AW]));
            chk("ub_wdata", 32'(ub_wdata), 32'(d[g*DW +: DW]));
        end else begin
            chk("ub_idle", 32'({ub_wr_en, ub_addr, ub_wdata}), 32'(0));
        end
        if (track) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
            chk("rvalid_onehot0", 32'($onehot0(rvalid)), 32'(1));
            rvalid_seen += $countones(rvalid);
            if (g >= 0 && !w[g]) reads_exp++;
            for (int i = 0; i < 3; i++) begin
                if (r[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        @(posedge clk);
        if (rs) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_rvalid = 3'b000;
        end else begin
            m_rvalid = (g >= 0 && !w[g]) ? eg : 3'b000;
            if (m_owner < 0) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % 3;
                    if (l[g]) begin
                        m_owner = g;
                        m_held  = 1;
                    end
                end
            end else if (g < 0) begin
                m_ptr = (m_owner + 1) % 3;
                m_owner = -1;
            end else begin
                m_held++;
                if (!l[m_owner] || m_held == ML) begin
                    m_ptr = (m_owner + 1) % 3;
                    m_owner = -1;
                end
            end
        end
        #1;
    endtask

    initial begin
        // Reset with everyone requesting: nothing may be granted.
        do_cycle(1, 3'b111, 3'b000, 3'b000, '0, '0);
        chk("rst_gnt", 32'(obs_gnt), 32'(0));
        do_cycle(1, 3'b111, 3'b000, 3'b000, '0, '0);
        chk("rst_ub_req", 32'(obs_ub_req), 32'(0));

        // Full contention, no lock: strict rotation with reads echoed a cycle later.
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 3'b111, 3'b000, 3'b000, (3*AW)'($urandom), (3*DW)'($urandom));
            chk("rr_seq", 32'(obs_gnt), 32'(rr_seq[i]));
            if (i > 0) chk("rr_rvalid", 32'(obs_rvalid), 32'(rr_seq[i-1]));
            else chk("rr_rvalid_first", 32'(obs_rvalid), 32'(0));
        end
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);
        chk("rr_rvalid_last", 32'(obs_rvalid), 32'(3'b100));

        // Lone host write.
        do_cycle(0, 3'b010, 3'b010, 3'b000, {8'h00, 8'h10, 8'h00}, {8'h00, 8'hA5, 8'h00});
        chk("host_wr_gnt", 32'(obs_gnt), 32'(3'b010));
        chk("host_wr_en", 32'(obs_ub_wr), 32'(1));
        chk("host_wr_addr", 32'(obs_addr), 32'(8'h10));
        chk("host_wr_data", 32'(obs_wdata), 32'(8'hA5));
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);
        chk("host_wr_no_rvalid", 32'(obs_rvalid), 32'(0));

        // PPU locks against a continuously requesting CU; released after ML cycles.
        for (int c = 1; c <= 20; c++) begin
            do_cycle(0, 3'b101, 3'b000, 3'b100, (3*AW)'($urandom), (3*DW)'($urandom));
            if (c <= ML) chk("lock_hold", 32'(obs_gnt), 32'(3'b100));
            if (c == ML + 1) chk("lock_max_release", 32'(obs_gnt), 32'(3'b001));
        end
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);
        chk("owner_drop_bubble", 32'(obs_gnt), 32'(0));

        // CU locks three cycles, drops lock on the fourth; host waits then wins.
        for (int c = 1; c <= 5; c++) begin
            do_cycle(0, 3'b011, 3'b000, (c <= 3) ? 3'b001 : 3'b000,
                     (3*AW)'($urandom), (3*DW)'($urandom));
            if (c <= 4) chk("cu_lock", 32'(obs_gnt), 32'(3'b001));
            else chk("host_after_unlock", 32'(obs_gnt), 32'(3'b010));
        end
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);

        // Reset in the middle of an ownership.
        do_cycle(0, 3'b111, 3'b000, 3'b111, (3*AW)'($urandom), (3*DW)'($urandom));
        chk("pre_rst_lock", 32'(obs_gnt), 32'(3'b100));
        do_cycle(0, 3'b111, 3'b000, 3'b111, (3*AW)'($urandom), (3*DW)'($urandom));
        chk("pre_rst_owned", 32'(obs_gnt), 32'(3'b100));
        do_cycle(1, 3'b111, 3'b000, 3'b111, (3*AW)'($urandom), (3*DW)'($urandom));
        chk("mid_rst_gnt", 32'(obs_gnt), 32'(0));
        chk("mid_rst_ub_req", 32'(obs_ub_req), 32'(0));
        do_cycle(0, 3'b111, 3'b000, 3'b000, (3*AW)'($urandom), (3*DW)'($urandom));
        chk("post_rst_gnt", 32'(obs_gnt), 32'(3'b001));
        chk("post_rst_rvalid", 32'(obs_rvalid), 32'(0));
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);

        // Random traffic with lock biased on to exercise long ownerships.
        track = 1;
        for (int n = 0; n < 10000; n++) begin
            do_cycle(0, 3'($urandom), 3'($urandom), 3'($urandom | $urandom),
                     (3*AW)'($urandom), (3*DW)'($urandom));
        end
        do_cycle(0, 3'b000, 3'b000, 3'b000, '0, '0);
        track = 0;
        chk("read_rvalid_pairing", 32'(rvalid_seen), 32'(reads_exp));
        // Worst case a waiter sits behind two full ownerships before its turn.
        chk("max_wait_bound", 32'(max_wait <= 2 * ML), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
